addsub_digit_serial: RTL and testbench
======================================

Name: addsub_digit_serial

Overview:
- Parametrised, clocked add/subtract unit; successor to the combinational 4-bit ripple-carry adder.
- Processes WIDTH-bit operands DIGIT bits per clock, LSB digit first, through one shared DIGIT-bit adder slice.
- Provides a start/ready/done handshake, an add/subtract mode, a signed overflow flag and a registered result.
- Used where area matters more than latency; instantiated by datapath blocks that issue one operation at a time.

Parameters:
- WIDTH, 8, operand and result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 2, bits processed per cycle; must satisfy 1 <= DIGIT <= WIDTH.
- NDIG (localparam), WIDTH/DIGIT, number of RUN cycles per operation.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted on a rising edge when ready=1.
- sub  input  1  mode select, sampled with start: 0 = add, 1 = subtract.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- cin  input  1  carry-in for add, borrow-in for subtract; sampled with start.
- ready  output  1  high in IDLE and DONE; start is accepted only when ready=1.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result is valid.
- s  output  WIDTH  result; holds the last completed value.
- cout  output  1  add: carry out; subtract: 1 = no borrow, 0 = borrow.
- ovf  output  1  two's-complement overflow of the last completed operation.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, digit counter=0, internal regs=0.
- Reset output values: s=0, cout=0, ovf=0, done=0, busy=0, ready=1.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, latch a and the effective B operand.
  - Effective B = sub ? ~b : b.
  - Initial carry c0 = cin XOR sub.
  - Set counter=0 and go to RUN.
- Resulting arithmetic:
  - add: a + b + cin.
  - subtract: a - b - cin, computed as a + ~b + ~cin.
- RUN: each edge adds digit[cnt] of A and effective B plus the carry register.
  - The DIGIT-bit sum goes into accumulator bits [cnt*DIGIT +: DIGIT]; the carry register takes the digit carry-out.
  - Counter increments each edge.
  - When cnt = NDIG-1, the edge also:
    - copies the full accumulator to s;
    - sets cout = final carry;
    - sets ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1);
    - goes to DONE.
- s, cout and ovf never show partial results; they change only on the final RUN edge, and on reset.
- DONE: lasts exactly one cycle; done=1 and ready=1.
  - start=1 here is accepted exactly as in IDLE: back-to-back operation, next state RUN.
  - Otherwise the next state is IDLE.
- Latency: start sampled at edge E0; the result is registered at edge E(NDIG); done is high from E(NDIG) to E(NDIG+1).
- Throughput: one operation per NDIG+1 cycles.
- start while busy=1 is ignored; no queueing; the operation in flight is unaffected.
- Changes on a, b, sub or cin after acceptance have no effect.
- DIGIT=WIDTH: NDIG=1; still exactly one RUN cycle and the same handshake.
- Wrap-around: the result is truncated to WIDTH bits; overflow is reported only through cout and ovf.
- Reset asserted mid-RUN or in DONE: the operation is aborted immediately and all outputs return to their reset values; no done pulse is issued.

Test Plan (WIDTH=8, DIGIT=2, NDIG=4):
- Add with carry chain: start, sub=0, a=0x0F, b=0x01, cin=0.
  - Required: busy for 4 cycles; done pulses at the 4th edge after acceptance; s=0x10, cout=0, ovf=0.
- Signed overflow and full wrap:
  - a=0x7F, b=0x01, add: s=0x80, cout=0, ovf=1.
  - a=0xFF, b=0x01, cin=1: s=0x01, cout=1, ovf=0.
- Subtract with borrow and signed overflow:
  - a=0x05, b=0x07, sub=1: s=0xFE, cout=0, ovf=0.
  - a=0x80, b=0x01, sub=1: s=0x7F, cout=1, ovf=1.
  - a=0x10, b=0x01, sub=1, cin=1: s=0x0E.
- Handshake: pulse start in cycle 2 of RUN with different operands.
  - Required: ignored, first result unchanged.
  - start held during the DONE cycle is accepted; second done exactly 5 cycles after the first.
- Reset mid-operation: drop rst_n during the 2nd RUN cycle.
  - Required: s=0, cout=0, ovf=0, busy=0, ready=1 immediately, with no clock edge; no done pulse.
  - A new start after release completes normally.
- Parameter sweep: DIGIT=1 and DIGIT=8 with 1000 random operand/mode sets each.
  - Required: s, cout and ovf match a reference model.
  - Required latency: 8 RUN cycles for DIGIT=1, 1 RUN cycle for DIGIT=8.

Source files
------------

// File: rtl/addsub_digit_serial.sv
// addsub_digit_serial
// Digit-serial add/subtract unit. WIDTH-bit operands are consumed DIGIT bits
// per clock, least significant digit first, through one shared DIGIT-bit adder
// slice. A start/ready/done handshake frames each operation; the result, the
// carry/no-borrow flag and the signed overflow flag are registered and only
// ever updated on the final digit of an operation (or cleared by reset).
module addsub_digit_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   // Number of RUN cycles per operation and the counter that walks the digits.
   // The counter keeps at least one bit so the DIGIT == WIDTH case still has
   // a legal register.
   localparam int NDIG  = WIDTH / DIGIT;
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Control state
   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;

   // Operand and working registers
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;      // effective B: already inverted for subtract
   logic               r_carry;  // carry between digits
   logic [WIDTH-1:0]   r_acc;    // partial sum, filled one digit at a time

   // Architectural result registers
   logic [WIDTH-1:0]   r_s;
   logic               r_cout;
   logic               r_ovf;

   // Digit slice signals
   logic [DIGIT-1:0]   w_a_dig;
   logic [DIGIT-1:0]   w_b_dig;
   logic [DIGIT:0]     w_dsum_ext;
   logic [DIGIT-1:0]   w_dsum;
   logic               w_dcarry;
   logic               w_cin_msb;
   logic [WIDTH-1:0]   w_acc_next;
   logic               w_last;

   // Select the operand digits addressed by the digit counter.
   always_comb begin
      w_a_dig = '0;
      w_b_dig = '0;
      for (int k = 0; k < NDIG; k++) begin
         if (int'(r_cnt) == k) begin
            w_a_dig = r_a[k*DIGIT +: DIGIT];
            w_b_dig = r_b[k*DIGIT +: DIGIT];
         end
      end
   end

   // The one shared DIGIT-bit adder slice with carry-in from the previous digit.
   assign w_dsum_ext = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
   assign w_dsum     = w_dsum_ext[DIGIT-1:0];
   assign w_dcarry   = w_dsum_ext[DIGIT];

   // Carry into the most significant bit of the current digit. On the last
   // digit this is the carry into bit WIDTH-1, which together with the carry
   // out of that bit gives two's-complement overflow.
   assign w_cin_msb  = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_dsum[DIGIT-1];

   assign w_last     = (r_cnt == LAST);

   // Merge the freshly computed digit into the accumulator image, so the final
   // edge can copy the complete sum straight into the result register.
   always_comb begin
      w_acc_next = r_acc;
      for (int k = 0; k < NDIG; k++) begin
         if (int'(r_cnt) == k) begin
            w_acc_next[k*DIGIT +: DIGIT] = w_dsum;
         end
      end
   end

   // Control FSM with registered handshake outputs, operand capture and the
   // digit-by-digit accumulation; result flags change only on the last digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_acc   <= '0;
         r_s     <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            // IDLE and DONE accept a request identically; DONE additionally
            // retires the one-cycle done pulse.
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  r_carry <= cin ^ sub;
                  r_cnt   <= '0;
                  r_acc   <= '0;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end else begin
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end

            ST_RUN: begin
               r_acc   <= w_acc_next;
               r_carry <= w_dcarry;
               if (w_last) begin
                  r_s     <= w_acc_next;
                  r_cout  <= w_dcarry;
                  r_ovf   <= w_cin_msb ^ w_dcarry;
                  r_cnt   <= '0;
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end

            default: begin
               r_cnt   <= '0;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready = r_ready;
   assign busy  = r_busy;
   assign done  = r_done;
   assign s     = r_s;
   assign cout  = r_cout;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_addsub_digit_serial.sv
// tb_addsub_digit_serial
// Self-checking bench for addsub_digit_serial. Three instances (DIGIT = 2, 1
// and 8, WIDTH = 8) share operands and reset; each has its own start and
// outputs. Expected results are pushed to a per-instance queue when an
// operation is launched and popped when that instance raises done.
module tb_addsub_digit_serial;

   typedef struct packed {
      logic [7:0] s;
      logic       c;
      logic       v;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic       cin;
      exp_t       e;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       sub;
   logic       cin;
   logic [7:0] a;
   logic [7:0] b;

   logic       start2, ready2, busy2, done2, cout2, ovf2;
   logic [7:0] s2;
   logic       start1, ready1, busy1, done1, cout1, ovf1;
   logic [7:0] s1;
   logic       start8, ready8, busy8, done8, cout8, ovf8;
   logic [7:0] s8;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t q2[$];
   exp_t q1[$];
   exp_t q8[$];

   addsub_digit_serial #(.WIDTH(8), .DIGIT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub), .a(a), .b(b), .cin(cin),
      .ready(ready2), .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2)
   );

   addsub_digit_serial #(.WIDTH(8), .DIGIT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
      .ready(ready1), .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
   );

   addsub_digit_serial #(.WIDTH(8), .DIGIT(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub), .a(a), .b(b), .cin(cin),
      .ready(ready8), .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Whole-word integer reference: unsigned sum/difference for s and cout,
   // signed sum/difference range check for ovf.
   function automatic exp_t model(input logic [7:0] xa, input logic [7:0] xb,
                                  input logic xs, input logic xc);
      exp_t r;
      int   ur;
      int   sr;
      if (!xs) begin
         ur = int'(xa) + int'(xb) + int'(xc);
         sr = int'($signed(xa)) + int'($signed(xb)) + int'(xc);
         r.c = (ur > 255);
      end else begin
         ur = int'(xa) - int'(xb) - int'(xc);
         sr = int'($signed(xa)) - int'($signed(xb)) - int'(xc);
         r.c = (ur >= 0);
      end
      r.s = ur[7:0];
      r.v = (sr > 127) || (sr < -128);
      return r;
   endfunction

   function automatic logic get_done(input int w);
      case (w)
         1:       return done1;
         8:       return done8;
         default: return done2;
      endcase
   endfunction

   function automatic logic get_busy(input int w);
      case (w)
         1:       return busy1;
         8:       return busy8;
         default: return busy2;
      endcase
   endfunction

   function automatic exp_t get_res(input int w);
      exp_t r;
      case (w)
         1:       r = '{s1, cout1, ovf1};
         8:       r = '{s8, cout8, ovf8};
         default: r = '{s2, cout2, ovf2};
      endcase
      return r;
   endfunction

   // Present operands with start for one rising edge on the chosen instance.
   task automatic launch(input int w, input logic [7:0] xa, input logic [7:0] xb,
                         input logic xs, input logic xc);
      a   = xa;
      b   = xb;
      sub = xs;
      cin = xc;
      case (w)
         1:       start1 = 1'b1;
         8:       start8 = 1'b1;
         default: start2 = 1'b1;
      endcase
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start2 = 1'b0;
      start8 = 1'b0;
   endtask

   // Count edges until done is seen (bounded), and the cycles spent busy.
   task automatic wait_done(input int w, input int budget, output int cyc,
                            output int bcnt, output bit to);
      cyc  = 0;
      bcnt = get_busy(w) ? 1 : 0;
      to   = 1'b1;
      while (to && (cyc < budget)) begin
         @(posedge clk);
         #1;
         cyc++;
         if (get_done(w)) to = 1'b0;
         else if (get_busy(w)) bcnt++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      n_vec++; if (s2 !== 8'h00)  begin n_err++; $display("FAIL reset_s got %h want 00", s2); end
      n_vec++; if (cout2 !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b want 0", cout2); end
      n_vec++; if (ovf2 !== 1'b0)  begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf2); end
      n_vec++; if (done2 !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done2); end
      n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy2); end
      n_vec++; if (ready2 !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready2); end
      n_vec++; if (ready1 !== 1'b1) begin n_err++; $display("FAIL reset_ready_d1 got %b want 1", ready1); end
      n_vec++; if (ready8 !== 1'b1) begin n_err++; $display("FAIL reset_ready_d8 got %b want 1", ready8); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_add_carry();
      exp_t e;
      exp_t r;
      int   cyc, bc;
      bit   to;
      q2.push_back('{8'h10, 1'b0, 1'b0});
      launch(2, 8'h0F, 8'h01, 1'b0, 1'b0);
      wait_done(2, 20, cyc, bc, to);
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL add_timeout got timeout want done"); end
      n_vec++; if (cyc != 4) begin n_err++; $display("FAIL add_latency got %0d want 4", cyc); end
      n_vec++; if (bc != 4) begin n_err++; $display("FAIL add_busy_cycles got %0d want 4", bc); end
      n_vec++; if (ready2 !== 1'b1) begin n_err++; $display("FAIL add_ready_in_done got %b want 1", ready2); end
      e = q2.pop_front();
      r = get_res(2);
      n_vec++; if (r.s !== e.s) begin n_err++; $display("FAIL add_s got %h want %h", r.s, e.s); end
      n_vec++; if (r.c !== e.c) begin n_err++; $display("FAIL add_cout got %b want %b", r.c, e.c); end
      n_vec++; if (r.v !== e.v) begin n_err++; $display("FAIL add_ovf got %b want %b", r.v, e.v); end
      @(posedge clk);
      #1;
      n_vec++; if (done2 !== 1'b0) begin n_err++; $display("FAIL add_done_pulse got %b want 0", done2); end
   endtask

   task automatic test_overflow();
      vec_t v[2];
      exp_t e;
      exp_t r;
      int   cyc, bc;
      bit   to;
      v[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b1}};
      v[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, '{8'h01, 1'b1, 1'b0}};
      for (int i = 0; i < 2; i++) begin
         q2.push_back(v[i].e);
         launch(2, v[i].a, v[i].b, v[i].sub, v[i].cin);
         wait_done(2, 20, cyc, bc, to);
         n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL ovf_timeout[%0d] got timeout want done", i); end
         e = q2.pop_front();
         r = get_res(2);
         n_vec++; if (r.s !== e.s) begin n_err++; $display("FAIL ovf_s[%0d] got %h want %h", i, r.s, e.s); end
         n_vec++; if (r.c !== e.c) begin n_err++; $display("FAIL ovf_cout[%0d] got %b want %b", i, r.c, e.c); end
         n_vec++; if (r.v !== e.v) begin n_err++; $display("FAIL ovf_ovf[%0d] got %b want %b", i, r.v, e.v); end
      end
   endtask

   task automatic test_subtract();
      vec_t v[3];
      exp_t e;
      exp_t r;
      int   cyc, bc;
      bit   to;
      v[0] = '{8'h05, 8'h07, 1'b1, 1'b0, '{8'hFE, 1'b0, 1'b0}};
      v[1] = '{8'h80, 8'h01, 1'b1, 1'b0, '{8'h7F, 1'b1, 1'b1}};
      v[2] = '{8'h10, 8'h01, 1'b1, 1'b1, '{8'h0E, 1'b1, 1'b0}};
      for (int i = 0; i < 3; i++) begin
         q2.push_back(v[i].e);
         launch(2, v[i].a, v[i].b, v[i].sub, v[i].cin);
         wait_done(2, 20, cyc, bc, to);
         n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL sub_timeout[%0d] got timeout want done", i); end
         e = q2.pop_front();
         r = get_res(2);
         n_vec++; if (r.s !== e.s) begin n_err++; $display("FAIL sub_s[%0d] got %h want %h", i, r.s, e.s); end
         n_vec++; if (r.c !== e.c) begin n_err++; $display("FAIL sub_cout[%0d] got %b want %b", i, r.c, e.c); end
         n_vec++; if (r.v !== e.v) begin n_err++; $display("FAIL sub_ovf[%0d] got %b want %b", i, r.v, e.v); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      exp_t r;
      int   cyc, bc;
      bit   to;
      @(posedge clk);
      #1;
      q2.push_back('{8'h10, 1'b0, 1'b0});
      launch(2, 8'h0F, 8'h01, 1'b0, 1'b0);
      // Second RUN cycle: a start with different operands must be ignored.
      @(posedge clk);
      #1;
      a = 8'h55; b = 8'h22; sub = 1'b1; cin = 1'b1;
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      wait_done(2, 20, cyc, bc, to);
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL b2b_first_timeout got timeout want done"); end
      n_vec++; if (cyc != 2) begin n_err++; $display("FAIL b2b_first_remaining got %0d want 2", cyc); end
      e = q2.pop_front();
      r = get_res(2);
      n_vec++; if (r.s !== e.s) begin n_err++; $display("FAIL b2b_first_s got %h want %h", r.s, e.s); end
      n_vec++; if (r.c !== e.c) begin n_err++; $display("FAIL b2b_first_cout got %b want %b", r.c, e.c); end
      n_vec++; if (r.v !== e.v) begin n_err++; $display("FAIL b2b_first_ovf got %b want %b", r.v, e.v); end
      n_vec++; if (ready2 !== 1'b1) begin n_err++; $display("FAIL b2b_ready_in_done got %b want 1", ready2); end
      // Start during the DONE cycle is accepted.
      q2.push_back('{8'h7F, 1'b1, 1'b1});
      launch(2, 8'h80, 8'h01, 1'b1, 1'b0);
      wait_done(2, 20, cyc, bc, to);
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL b2b_second_timeout got timeout want done"); end
      n_vec++; if (cyc + 1 != 5) begin n_err++; $display("FAIL b2b_done_gap got %0d want 5", cyc + 1); end
      e = q2.pop_front();
      r = get_res(2);
      n_vec++; if (r.s !== e.s) begin n_err++; $display("FAIL b2b_second_s got %h want %h", r.s, e.s); end
      n_vec++; if (r.c !== e.c) begin n_err++; $display("FAIL b2b_second_cout got %b want %b", r.c, e.c); end
      n_vec++; if (r.v !== e.v) begin n_err++; $display("FAIL b2b_second_ovf got %b want %b", r.v, e.v); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      exp_t r;
      int   cyc, bc, dn;
      bit   to;
      @(posedge clk);
      #1;
      launch(2, 8'h33, 8'h11, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++; if (s2 !== 8'h00)   begin n_err++; $display("FAIL midrst_s got %h want 00", s2); end
      n_vec++; if (cout2 !== 1'b0) begin n_err++; $display("FAIL midrst_cout got %b want 0", cout2); end
      n_vec++; if (ovf2 !== 1'b0)  begin n_err++; $display("FAIL midrst_ovf got %b want 0", ovf2); end
      n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy2); end
      n_vec++; if (ready2 !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b want 1", ready2); end
      dn = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (done2) dn++;
      end
      rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done2) dn++;
      end
      n_vec++; if (dn != 0) begin n_err++; $display("FAIL midrst_no_done got %0d pulses want 0", dn); end
      q2.push_back('{8'h44, 1'b0, 1'b0});
      launch(2, 8'h33, 8'h11, 1'b0, 1'b0);
      wait_done(2, 20, cyc, bc, to);
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL midrst_after_timeout got timeout want done"); end
      n_vec++; if (cyc != 4) begin n_err++; $display("FAIL midrst_after_latency got %0d want 4", cyc); end
      e = q2.pop_front();
      r = get_res(2);
      n_vec++; if (r.s !== e.s) begin n_err++; $display("FAIL midrst_after_s got %h want %h", r.s, e.s); end
      n_vec++; if (r.c !== e.c) begin n_err++; $display("FAIL midrst_after_cout got %b want %b", r.c, e.c); end
      n_vec++; if (r.v !== e.v) begin n_err++; $display("FAIL midrst_after_ovf got %b want %b", r.v, e.v); end
   endtask

   task automatic test_sweep(input int w);
      exp_t       e;
      exp_t       r;
      int         cyc, bc, lat;
      bit         to;
      logic [7:0] xa, xb;
      logic       xs, xc;
      lat = 8 / w;
      for (int i = 0; i < 1000; i++) begin
         xa = 8'($urandom);
         xb = 8'($urandom);
         xs = 1'($urandom);
         xc = 1'($urandom);
         if (w == 1) q1.push_back(model(xa, xb, xs, xc));
         else        q8.push_back(model(xa, xb, xs, xc));
         launch(w, xa, xb, xs, xc);
         wait_done(w, 30, cyc, bc, to);
         n_vec++;
         if (to !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_d%0d_timeout[%0d] got timeout want done", w, i);
         end
         n_vec++;
         if (cyc != lat) begin
            n_err++;
            $display("FAIL sweep_d%0d_latency[%0d] got %0d want %0d", w, i, cyc, lat);
         end
         e = (w == 1) ? q1.pop_front() : q8.pop_front();
         r = get_res(w);
         n_vec++;
         if (r.s !== e.s) begin
            n_err++;
            $display("FAIL sweep_d%0d_s[%0d] a=%h b=%h sub=%b cin=%b got %h want %h",
                     w, i, xa, xb, xs, xc, r.s, e.s);
         end
         n_vec++;
         if (r.c !== e.c) begin
            n_err++;
            $display("FAIL sweep_d%0d_cout[%0d] a=%h b=%h sub=%b cin=%b got %b want %b",
                     w, i, xa, xb, xs, xc, r.c, e.c);
         end
         n_vec++;
         if (r.v !== e.v) begin
            n_err++;
            $display("FAIL sweep_d%0d_ovf[%0d] a=%h b=%h sub=%b cin=%b got %b want %b",
                     w, i, xa, xb, xs, xc, r.v, e.v);
         end
      end
   endtask

   initial begin
      start1 = 1'b0;
      start2 = 1'b0;
      start8 = 1'b0;
      a      = 8'h00;
      b      = 8'h00;
      sub    = 1'b0;
      cin    = 1'b0;
      test_reset();
      test_add_carry();
      test_overflow();
      test_subtract();
      test_back_to_back();
      test_reset_mid();
      test_sweep(1);
      test_sweep(8);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
